mtl_lcd_tx: RTL and testbench

- Pixel transmitter for the MTL multi-touch LCD panel: the sending end of the DCLK/HSD/VSD/RGB interface that the panel and the frame-dump bench receive.
- Generates 1056x525 raster timing and reads NES pixels from the frame buffer read port.
- Scales the 256x240 NES image 3x horizontally and 2x vertically into the 800x480 visible window. The image is centred with 16-pixel side borders.
- Sits between the PPU frame buffer and the top-level MTL_* pins.

---
 rtl/mtl_lcd_tx.sv | 136 +++++++++++++
 tb/tb_mtl_lcd_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mtl_lcd_tx.sv
// MTL LCD pixel transmitter: raster timing, NES frame-buffer reads with 3x/2x scaling
// and a two-stage output pipeline so every pin describes the same coordinate.
module mtl_lcd_tx #(
    parameter int H_TOTAL  = 1056,
    parameter int V_TOTAL  = 525,
    parameter int H_SYNC   = 30,
    parameter int V_SYNC   = 13,
    parameter int H_ACT0   = 50,
    parameter int V_ACT0   = 23,
    parameter int H_ACT    = 800,
    parameter int V_ACT    = 480,
    parameter int H_BORDER = 16
) (
    input  logic        i_lcd_clk,
    input  logic        i_rstn_lcd,
    input  logic [23:0] i_border_rgb,
    output logic        o_fb_rd,
    output logic [15:0] o_fb_addr,
    input  logic [23:0] i_fb_rdata,
    output logic        o_hsd,
    output logic        o_vsd,
    output logic        o_de,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_vblank,
    output logic        o_frame_start
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_HS   = 11'(H_SYNC);
    localparam logic [10:0] H_VIS0 = 11'(H_ACT0);
    localparam logic [10:0] H_VIS1 = 11'(H_ACT0 + H_ACT);
    localparam logic [10:0] H_IMG0 = 11'(H_ACT0 + H_BORDER);
    localparam logic [10:0] H_IMG1 = 11'(H_ACT0 + H_ACT - H_BORDER);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VS   = 10'(V_SYNC);
    localparam logic [9:0]  V_VIS0 = 10'(V_ACT0);
    localparam logic [9:0]  V_VIS1 = 10'(V_ACT0 + V_ACT);

    logic [10:0] h_p0;
    logic [9:0]  v_p0;
    logic [1:0]  phase_p0;
    logic [7:0]  nes_x_p0;

    logic        hs_p0, vs_p0, line_vis_p0, vis_p0, img_p0, first_p0, fs_p0;
    logic [1:0]  phase_cur;
    logic [7:0]  nes_x_cur;
    logic [7:0]  nes_y_p0;

    logic        vld_p1, vis_p1, hs_p1, vs_p1, line_vis_p1, fs_p1;
    logic [23:0] rgb_p2;

    // stage 0: raster decode; the first image column restarts the 3x replication phase
    always_comb begin
        hs_p0       = h_p0 < H_HS;
        vs_p0       = v_p0 < V_VS;
        line_vis_p0 = (v_p0 >= V_VIS0) && (v_p0 < V_VIS1);
        vis_p0      = line_vis_p0 && (h_p0 >= H_VIS0) && (h_p0 < H_VIS1);
        img_p0      = line_vis_p0 && (h_p0 >= H_IMG0) && (h_p0 < H_IMG1);
        first_p0    = img_p0 && (h_p0 == H_IMG0);
        fs_p0       = (h_p0 == 11'd0) && (v_p0 == 10'd0);
        phase_cur   = first_p0 ? 2'd0 : phase_p0;
        nes_x_cur   = first_p0 ? 8'd0 : nes_x_p0;
        nes_y_p0    = 8'((v_p0 - V_VIS0) >> 1);
    end

    always_ff @(posedge i_lcd_clk or negedge i_rstn_lcd) begin
        if (!i_rstn_lcd) begin
            h_p0     <= '0;
            v_p0     <= '0;
            phase_p0 <= '0;
            nes_x_p0 <= '0;
        end else begin
            if (h_p0 == H_LAST) begin
                h_p0 <= '0;
                v_p0 <= (v_p0 == V_LAST) ? 10'd0 : v_p0 + 10'd1;
            end else begin
                h_p0 <= h_p0 + 11'd1;
            end
            if (img_p0) begin
                phase_p0 <= (phase_cur == 2'd2) ? 2'd0 : phase_cur + 2'd1;
                nes_x_p0 <= (phase_cur == 2'd2) ? nes_x_cur + 8'd1 : nes_x_cur;
            end
        end
    end

    // stage 1: frame-buffer request plus the control that travels with it
    always_ff @(posedge i_lcd_clk or negedge i_rstn_lcd) begin
        if (!i_rstn_lcd) begin
            vld_p1      <= 1'b0;
            o_fb_addr   <= '0;
            vis_p1      <= 1'b0;
            hs_p1       <= 1'b0;
            vs_p1       <= 1'b0;
            line_vis_p1 <= 1'b0;
            fs_p1       <= 1'b0;
        end else begin
            vld_p1      <= img_p0;
            if (img_p0) o_fb_addr <= {nes_y_p0, nes_x_cur};
            vis_p1      <= vis_p0;
            hs_p1       <= hs_p0;
            vs_p1       <= vs_p0;
            line_vis_p1 <= line_vis_p0;
            fs_p1       <= fs_p0;
        end
    end

    assign o_fb_rd = vld_p1;

    // stage 2: pixel select and pin registers
    always_ff @(posedge i_lcd_clk or negedge i_rstn_lcd) begin
        if (!i_rstn_lcd) begin
            rgb_p2        <= '0;
            o_hsd         <= 1'b1;
            o_vsd         <= 1'b1;
            o_de          <= 1'b0;
            o_vblank      <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            if (vld_p1)      rgb_p2 <= i_fb_rdata;
            else if (vis_p1) rgb_p2 <= i_border_rgb;
            else             rgb_p2 <= '0;
            o_hsd         <= ~hs_p1;
            o_vsd         <= ~vs_p1;
            o_de          <= vis_p1;
            o_vblank      <= ~line_vis_p1;
            o_frame_start <= fs_p1;
        end
    end

    assign o_r = rgb_p2[23:16];
    assign o_g = rgb_p2[15:8];
    assign o_b = rgb_p2[7:0];

endmodule

// File: tb/tb_mtl_lcd_tx.sv
// Bench for mtl_lcd_tx: full-width lines with a short frame, checked cycle by cycle
// against a coordinate-based model of the panel timing and NES scaling.
module tb_mtl_lcd_tx;

    localparam int H_TOTAL  = 1056;
    localparam int V_TOTAL  = 10;
    localparam int H_SYNC   = 30;
    localparam int V_SYNC   = 2;
    localparam int H_ACT0   = 50;
    localparam int V_ACT0   = 3;
    localparam int H_ACT    = 800;
    localparam int V_ACT    = 6;
    localparam int H_BORDER = 16;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic        clk, rstn;
    logic [23:0] border, fb_rdata;
    logic        fb_rd, hsd, vsd, de, vblank, fs;
    logic [15:0] fb_addr;
    logic [7:0]  r, g, b;

    mtl_lcd_tx #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
        .H_ACT0(H_ACT0), .V_ACT0(V_ACT0), .H_ACT(H_ACT), .V_ACT(V_ACT), .H_BORDER(H_BORDER)
    ) dut (
        .i_lcd_clk(clk), .i_rstn_lcd(rstn), .i_border_rgb(border),
        .o_fb_rd(fb_rd), .o_fb_addr(fb_addr), .i_fb_rdata(fb_rdata),
        .o_hsd(hsd), .o_vsd(vsd), .o_de(de), .o_r(r), .o_g(g), .o_b(b),
        .o_vblank(vblank), .o_frame_start(fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int n;
    int last_hfall, last_vfall, de_cnt, rd_cnt;
    logic prev_hsd, prev_vsd;
    logic [23:0] border_q;
    logic [15:0] exp_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_hsd"}, 32'(hsd), 1);
        chk({tag, "_vsd"}, 32'(vsd), 1);
        chk({tag, "_de"}, 32'(de), 0);
        chk({tag, "_rgb"}, 32'({r, g, b}), 0);
        chk({tag, "_rd"}, 32'(fb_rd), 0);
        chk({tag, "_addr"}, 32'(fb_addr), 0);
        chk({tag, "_vblank"}, 32'(vblank), 1);
        chk({tag, "_fs"}, 32'(fs), 0);
    endtask

    function automatic logic in_img(input int ph, input int pv);
        return (pv >= V_ACT0) && (pv < V_ACT0 + V_ACT) &&
               (ph >= H_ACT0 + H_BORDER) && (ph < H_ACT0 + H_ACT - H_BORDER);
    endfunction

    function automatic logic [15:0] nes_addr(input int ph, input int pv);
        int nx, ny;
        nx = (ph - H_ACT0 - H_BORDER) / 3;
        ny = (pv - V_ACT0) / 2;
        return {8'(ny), 8'(nx)};
    endfunction

    task automatic start_after_reset();
        n = 0;
        last_hfall = -1;
        last_vfall = -1;
        prev_hsd = 1'b1;
        prev_vsd = 1'b1;
        de_cnt = 0;
        rd_cnt = 0;
        exp_addr = '0;
    endtask

    // One clock: check what the last edge produced, then drive the next inputs.
    task automatic cycle();
        int c, ph, pv;
        logic lv, e_de, im;
        logic [23:0] e_rgb;
        @(negedge clk);
        n++;
        if (n < 2) begin
            chk_reset_values("post_release");
        end else begin
            c  = (n - 2) % FRAME;
            ph = c % H_TOTAL;
            pv = c / H_TOTAL;
            lv = (pv >= V_ACT0) && (pv < V_ACT0 + V_ACT);
            e_de = lv && (ph >= H_ACT0) && (ph < H_ACT0 + H_ACT);
            im = in_img(ph, pv);
            e_rgb = im ? {8'h00, nes_addr(ph, pv)} : (e_de ? border_q : 24'h0);
            chk("hsd", 32'(hsd), 32'(ph >= H_SYNC));
            chk("vsd", 32'(vsd), 32'(pv >= V_SYNC));
            chk("de", 32'(de), 32'(e_de));
            chk("rgb", 32'({r, g, b}), 32'(e_rgb));
            chk("vblank", 32'(vblank), 32'(!lv));
            chk("frame_start", 32'(fs), 32'(c == 0));
            if (pv == V_ACT0) begin
                if (ph == 50 || ph == 65 || ph == 834 || ph == 849)
                    chk("line0_border", 32'({r, g, b}), 32'(border_q));
                if (ph == 66 || ph == 68) chk("line0_px0", 32'({r, g, b}), 32'h000000);
                if (ph == 69 || ph == 71) chk("line0_px1", 32'({r, g, b}), 32'h000001);
                if (ph == 831 || ph == 833) chk("line0_px255", 32'({r, g, b}), 32'h0000FF);
                if (ph == 850) chk("line0_after_vis", 32'({r, g, b}), 32'h000000);
            end
            if (pv == V_ACT0 + 1 && ph == 69) chk("line1_repeat", 32'({r, g, b}), 32'h000001);
            if (pv == V_ACT0 + 2 && ph == 69) chk("line2_row1", 32'({r, g, b}), 32'h000101);
        end
        if (n >= 1) begin
            c  = (n - 1) % FRAME;
            ph = c % H_TOTAL;
            pv = c / H_TOTAL;
            im = in_img(ph, pv);
            if (im) exp_addr = nes_addr(ph, pv);
            chk("fb_rd", 32'(fb_rd), 32'(im));
            chk("fb_addr", 32'(fb_addr), 32'(exp_addr));
        end
        if (prev_hsd && !hsd) begin
            if (last_hfall >= 0) chk("hsd_period", 32'(n - last_hfall), H_TOTAL);
            last_hfall = n;
        end
        if (!prev_hsd && hsd && last_hfall >= 0) chk("hsd_low", 32'(n - last_hfall), H_SYNC);
        if (prev_vsd && !vsd) begin
            if (last_vfall >= 0) chk("vsd_period", 32'(n - last_vfall), FRAME);
            last_vfall = n;
        end
        if (!prev_vsd && vsd && last_vfall >= 0)
            chk("vsd_low", 32'(n - last_vfall), V_SYNC * H_TOTAL);
        prev_hsd = hsd;
        prev_vsd = vsd;
        de_cnt += int'(de);
        rd_cnt += int'(fb_rd);
        fb_rdata = fb_rd ? {8'h00, fb_addr} : 24'($urandom);
        border   = 24'($urandom);
        border_q = border;
    endtask

    initial begin
        rstn = 1'b0;
        border = 24'h123456;
        border_q = border;
        fb_rdata = '0;
        start_after_reset();
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rstn = 1'b1;
        start_after_reset();

        repeat (2 * FRAME) cycle();
        chk("de_count", 32'(de_cnt), 2 * H_ACT * V_ACT);
        chk("rd_count", 32'(rd_cnt), 2 * (H_ACT - 2 * H_BORDER) * V_ACT);

        while ((n % FRAME) != 5 * H_TOTAL + 400) cycle();

        #2 rstn = 1'b0;
        #1 chk_reset_values("async_reset");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_reset_values("held_reset");
        end
        rstn = 1'b1;
        start_after_reset();

        cycle();
        cycle();
        chk("fs_after_release", 32'(fs), 1);
        repeat (FRAME + 4) cycle();
        chk("vsd_fall_after_release", 32'(last_vfall), 2 + FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
